// File: rtl/seq_chunk_adder_pkg.sv
// Shared constants for the chunked adder/subtractor: FSM state codes and
// default operand/chunk widths.
package seq_chunk_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle of the chunked adder. The requester (master) drives
// the operation fields and start; the adder (slave) drives status and result.
interface seq_chunk_adder_if
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             sub;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, c_in, a, b,
    input  ready, done, y, c_out, ovf, zero
  );

  modport slave (
    input  start, sub, c_in, a, b,
    output ready, done, y, c_out, ovf, zero
  );

endinterface

// File: rtl/seq_chunk_adder_adder_chunk.sv
// CHUNK-bit combinational ripple adder built from 1-bit full-adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             C_in,
  output logic [CHUNK-1:0] Y,
  output logic             C_out
);

  logic [CHUNK:0] carry_s;

  assign carry_s[0] = C_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry_s[i]),
      .s  (Y[i]),
      .co (carry_s[i+1])
    );
  end

  assign C_out = carry_s[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock with
// a registered carry between chunks. Results and flags update only on entry
// to DONE so the previous result stays visible while a new one is built.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic               clk,
  input  logic               rst,
  seq_chunk_adder_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             accept_s;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] y_r;
  logic             c_out_r;
  logic             ovf_r;
  logic             zero_r;
  logic             ready_r;
  logic             done_r;

  logic [CHUNK-1:0] sum_s;
  logic             chunk_co_s;
  logic             last_s;
  logic [WIDTH-1:0] final_s;

  adder_chunk #(.CHUNK(CHUNK)) u_adder_chunk (
    .A     (a_r[idx_r * CHUNK +: CHUNK]),
    .B     (b_r[idx_r * CHUNK +: CHUNK]),
    .C_in  (carry_r),
    .Y     (sum_s),
    .C_out (chunk_co_s)
  );

  assign last_s = (idx_r == IDX_W'(NCHUNK - 1));

  // Next state and acceptance of a new request.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_BUSY;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_nxt_s = ST_BUSY;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        accept_s    = 1'b0;
      end
    endcase
  end

  // Full result as it will look once the current chunk is written.
  always_comb begin
    final_s = acc_r;
    final_s[idx_r * CHUNK +: CHUNK] = sum_s;
  end

  // FSM, operand latch, chunk accumulation and result/flag publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      acc_r   <= '0;
      y_r     <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s != ST_BUSY);
      done_r  <= (state_nxt_s == ST_DONE);
      if (accept_s) begin
        a_r     <= bus.a;
        b_r     <= bus.sub ? ~bus.b : bus.b;
        carry_r <= bus.sub ? 1'b1 : bus.c_in;
        idx_r   <= '0;
      end else if (state_r == ST_BUSY) begin
        acc_r   <= final_s;
        carry_r <= chunk_co_s;
        idx_r   <= idx_r + IDX_W'(1);
        if (last_s) begin
          y_r     <= final_s;
          c_out_r <= chunk_co_s;
          ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (final_s[WIDTH-1] != a_r[WIDTH-1]);
          zero_r  <= (final_s == '0);
        end
      end
    end
  end

  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign bus.y     = y_r;
  assign bus.c_out = c_out_r;
  assign bus.ovf   = ovf_r;
  assign bus.zero  = zero_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: three instances (CHUNK = 4, 1, 16) share operand
// inputs; a selector routes start to one instance and muxes its outputs.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s = 1'b0;
  logic        sub_s = 1'b0;
  logic        c_in_s = 1'b0;
  logic [15:0] a_s = 16'h0000;
  logic [15:0] b_s = 16'h0000;
  int          sel = 0;

  int tests  = 0;
  int failed = 0;

  logic        obs_ready, obs_done, obs_c_out, obs_ovf, obs_zero;
  logic [15:0] obs_y;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) if4 ();
  seq_chunk_adder_if #(.WIDTH(16)) if1 ();
  seq_chunk_adder_if #(.WIDTH(16)) if16 ();

  assign if4.start  = start_s && (sel == 0);
  assign if1.start  = start_s && (sel == 1);
  assign if16.start = start_s && (sel == 2);
  assign if4.sub  = sub_s;  assign if1.sub  = sub_s;  assign if16.sub  = sub_s;
  assign if4.c_in = c_in_s; assign if1.c_in = c_in_s; assign if16.c_in = c_in_s;
  assign if4.a    = a_s;    assign if1.a    = a_s;    assign if16.a    = a_s;
  assign if4.b    = b_s;    assign if1.b    = b_s;    assign if16.b    = b_s;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  // Route the selected instance's outputs to the observation signals.
  always_comb begin
    case (sel)
      1: begin
        obs_ready = if1.ready; obs_done = if1.done; obs_y = if1.y;
        obs_c_out = if1.c_out; obs_ovf = if1.ovf; obs_zero = if1.zero;
      end
      2: begin
        obs_ready = if16.ready; obs_done = if16.done; obs_y = if16.y;
        obs_c_out = if16.c_out; obs_ovf = if16.ovf; obs_zero = if16.zero;
      end
      default: begin
        obs_ready = if4.ready; obs_done = if4.done; obs_y = if4.y;
        obs_c_out = if4.c_out; obs_ovf = if4.ovf; obs_zero = if4.zero;
      end
    endcase
  end

  function automatic int nchunk_of(input int s);
    case (s)
      1:       return 16;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  // Reference: {c_out, ovf, zero, y} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic ci);
    int          ua, ub, sa, sb, full, sr;
    logic [15:0] y;
    logic        co, v;
    ua = int'(a); ub = int'(b);
    sa = $signed(a); sb = $signed(b);
    if (s) begin
      full = ua - ub;
      co   = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub + int'(ci);
      co   = (full > 65535);
      sr   = sa + sb + int'(ci);
    end
    y = full[15:0];
    v = (sr > 32767) || (sr < -32768);
    return {co, v, (y == 16'h0000), y};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int s);
    sel = s;
    #1;
  endtask

  task automatic check_result(input string tag, input logic [18:0] exp);
    check({tag, "_y"},    32'(obs_y),     32'(exp[15:0]));
    check({tag, "_cout"}, 32'(obs_c_out), 32'(exp[18]));
    check({tag, "_ovf"},  32'(obs_ovf),   32'(exp[17]));
    check({tag, "_zero"}, 32'(obs_zero),  32'(exp[16]));
  endtask

  // One complete operation from IDLE, checking BUSY behaviour, latency,
  // the result in the DONE cycle and the single-cycle done pulse.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ci, input logic [18:0] exp);
    int          cyc;
    logic [15:0] prev_y;
    prev_y  = obs_y;
    check({tag, "_ready_idle"}, 32'(obs_ready), 32'd1);
    a_s = a; b_s = b; sub_s = s; c_in_s = ci; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    a_s = 16'($urandom); b_s = 16'($urandom);
    cyc = 0;
    while (!obs_done && cyc < 40) begin
      check({tag, "_ready_busy"}, 32'(obs_ready), 32'd0);
      check({tag, "_y_hold"},     32'(obs_y),     32'(prev_y));
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(nchunk_of(sel)));
    check({tag, "_ready_done"}, 32'(obs_ready), 32'd1);
    check_result(tag, exp);
    tick();
    check({tag, "_done_pulse"}, 32'(obs_done), 32'd0);
    check({tag, "_ready_after"}, 32'(obs_ready), 32'd1);
    check({tag, "_y_after"}, 32'(obs_y), 32'(exp[15:0]));
  endtask

  initial begin
    int          cyc;
    logic [15:0] ra, rb;
    logic        rs, rc;

    // Reset state of all three configurations.
    tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      check("rst_ready", 32'(obs_ready), 32'd1);
      check("rst_done",  32'(obs_done),  32'd0);
      check_result("rst", 19'h00000);
    end

    // CHUNK=4 directed cases.
    set_sel(0);
    do_op("add_cin", 16'h1234, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'h1236});
    do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 16'hFFFE});
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFF});

    // Start held through BUSY with changing operands, then held into DONE.
    a_s = 16'h1111; b_s = 16'h2222; sub_s = 1'b0; c_in_s = 1'b0; start_s = 1'b1;
    tick();
    cyc = 0;
    while (!obs_done && cyc < 40) begin
      check("hold_ready_busy", 32'(obs_ready), 32'd0);
      a_s = 16'($urandom); b_s = 16'($urandom); sub_s = 1'($urandom);
      tick();
      cyc++;
    end
    check("hold_latency", 32'(cyc), 32'd4);
    check_result("hold_first", {1'b0, 1'b0, 1'b0, 16'h3333});
    a_s = 16'h0F0F; b_s = 16'h0101; sub_s = 1'b0; c_in_s = 1'b0;
    tick();
    start_s = 1'b0;
    cyc = 1;
    while (!obs_done && cyc < 40) begin
      check("b2b_ready_busy", 32'(obs_ready), 32'd0);
      check("b2b_y_hold", 32'(obs_y), 32'h3333);
      tick();
      cyc++;
    end
    check("b2b_gap", 32'(cyc), 32'd5);
    check_result("b2b_second", {1'b0, 1'b0, 1'b0, 16'h1010});
    tick();
    check("b2b_done_pulse", 32'(obs_done), 32'd0);

    // Reset in the second BUSY cycle discards the operation.
    a_s = 16'h4321; b_s = 16'h1111; sub_s = 1'b0; c_in_s = 1'b0; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 32'(obs_ready), 32'd1);
    check("mid_rst_done",  32'(obs_done),  32'd0);
    check_result("mid_rst", 19'h00000);
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (obs_done) cyc++;
      tick();
    end
    check("mid_rst_no_done", 32'(cyc), 32'd0);
    do_op("post_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h1000});

    // CHUNK=1 and CHUNK=16 repeat of the first case.
    set_sel(1);
    do_op("c1_add", 16'h1234, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'h1236});
    set_sel(2);
    do_op("c16_add", 16'h1234, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'h1236});

    // Boundary and random regression on every configuration.
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      do_op("bnd_sub_eq", 16'h8000, 16'h8000, 1'b1, 1'b0, model(16'h8000, 16'h8000, 1'b1, 1'b0));
      do_op("bnd_neg_add", 16'h8000, 16'hFFFF, 1'b0, 1'b0, model(16'h8000, 16'hFFFF, 1'b0, 1'b0));
      for (int i = 0; i < 20; i++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
        do_op("rand", ra, rb, rs, rc, model(ra, rb, rs, rc));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
